// File: rtl/memory_arbiter_fsm_if.sv
// rtl/memory_arbiter_fsm_if.sv - shared types and core/RAM bus interface for memory_arbiter_fsm
package memory_arbiter_fsm_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IFETCH = 2'd0, DREAD = 2'd1, DWRITE = 2'd2} kind_e;
endpackage

interface memory_arbiter_fsm_if
  import memory_arbiter_fsm_pkg::*;
#(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [31:0]           ramload;
  ramstate_t             ramstate;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0][31:0] dload;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
  );
endinterface

// File: rtl/memory_arbiter_fsm.sv
// rtl/memory_arbiter_fsm.sv - IDLE/GRANT arbiter sharing one RAM among CPUS cores
// ARB_ROUNDROBIN_EN selects round-robin core selection; undefined gives fixed priority.
module memory_arbiter_fsm
  import memory_arbiter_fsm_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  memory_arbiter_fsm_if.master bus
);

  localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  kind_e           gkind_q, gkind_d;
  logic [IW-1:0]   base;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   sel_idx;
  logic            sel_found;
  kind_e           sel_kind;
  logic            req_active;
  logic            ram_ren, ram_wen;
  logic [31:0]     ram_addr, ram_store;
  logic [CPUS-1:0] iwait, dwait;

`ifdef ARB_ROUNDROBIN_EN
  logic [IW-1:0] rrptr_q, rrptr_d;
  assign base = rrptr_q;
`else
  assign base = '0;
`endif

  // Scan from base upward; within a core, writes beat data reads beat fetches.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_kind  = IFETCH;
    cand      = '0;
    for (int k = 0; k < CPUS; k++) begin
      cand = IW'((int'(base) + k) % CPUS);
      if (!sel_found && (bus.dWEN[cand] || bus.dREN[cand] || bus.iREN[cand])) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_kind  = bus.dWEN[cand] ? DWRITE : (bus.dREN[cand] ? DREAD : IFETCH);
      end
    end
  end

  always_comb begin
    case (gkind_q)
      DWRITE:  req_active = bus.dWEN[gidx_q];
      DREAD:   req_active = bus.dREN[gidx_q];
      IFETCH:  req_active = bus.iREN[gidx_q];
      default: req_active = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    gkind_d   = gkind_q;
`ifdef ARB_ROUNDROBIN_EN
    rrptr_d   = rrptr_q;
`endif
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    iwait     = '1;
    dwait     = '1;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = GRANT;
          gidx_d  = sel_idx;
          gkind_d = sel_kind;
        end
      end
      GRANT: begin
        // A dropped request abandons the grant without touching the RAM.
        if (!req_active) begin
          state_d = IDLE;
        end else begin
          case (gkind_q)
            DWRITE: begin
              ram_wen   = 1'b1;
              ram_addr  = bus.daddr[gidx_q];
              ram_store = bus.dstore[gidx_q];
            end
            DREAD: begin
              ram_ren  = 1'b1;
              ram_addr = bus.daddr[gidx_q];
            end
            IFETCH: begin
              ram_ren  = 1'b1;
              ram_addr = bus.iaddr[gidx_q];
            end
            default: ;
          endcase
          if (bus.ramstate == ACCESS) begin
            if (gkind_q == IFETCH) iwait[gidx_q] = 1'b0;
            else                   dwait[gidx_q] = 1'b0;
            state_d = IDLE;
`ifdef ARB_ROUNDROBIN_EN
            rrptr_d = IW'((int'(gidx_q) + 1) % CPUS);
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      gkind_q <= IFETCH;
`ifdef ARB_ROUNDROBIN_EN
      rrptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      gkind_q <= gkind_d;
`ifdef ARB_ROUNDROBIN_EN
      rrptr_q <= rrptr_d;
`endif
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = {CPUS{bus.ramload}};
  assign bus.dload    = {CPUS{bus.ramload}};

endmodule

// File: tb/tb_memory_arbiter_fsm.sv
// tb/tb_memory_arbiter_fsm.sv - directed bench with grant scoreboard for memory_arbiter_fsm
module tb_memory_arbiter_fsm;
  import memory_arbiter_fsm_pkg::*;

  localparam int CPUS = 2;
`ifdef ARB_ROUNDROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  memory_arbiter_fsm_if #(.CPUS(CPUS)) bus ();
  memory_arbiter_fsm #(.CPUS(CPUS)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  typedef struct {
    int          core;
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input int core, input int kind, input logic [31:0] addr,
                              input logic [31:0] data);
    exp_t e;
    e.core = core;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_ren"},   bus.ramREN,   1'b0);
    check({tag, "_wen"},   bus.ramWEN,   1'b0);
    check({tag, "_addr"},  bus.ramaddr,  32'h0);
    check({tag, "_store"}, bus.ramstore, 32'h0);
    check({tag, "_iwait"}, bus.iwait,    2'b11);
    check({tag, "_dwait"}, bus.dwait,    2'b11);
  endtask

  // Every low wait bit is a completed transfer; it must match the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    int   kind;
    for (int c = 0; c < CPUS; c++) begin
      if (bus.iwait[c] === 1'b0 || bus.dwait[c] === 1'b0) begin
        check("sb_expected_grant", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          e    = sb.pop_front();
          kind = bus.ramWEN ? 2 : ((bus.iwait[c] === 1'b0) ? 0 : 1);
          check("sb_core",  c,            e.core);
          check("sb_kind",  kind,         e.kind);
          check("sb_addr",  bus.ramaddr,  e.addr);
          check("sb_store", bus.ramstore, e.data);
          check("sb_load",  (kind == 0) ? bus.iload[c] : bus.dload[c], bus.ramload);
        end
      end
    end
  end

  initial begin
    int core;
    nRST         = 1'b0;
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;

    tick();
    tick();
    bus.dREN = 2'b11;
    #3 chk_idle("reset");
    tick();
    bus.dREN = '0;
    nRST     = 1'b1;
    #3 chk_idle("reset_held_req");
    tick();
    #3 chk_idle("post_reset");

    // Single fetch with immediate ACCESS
    tick();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h0000_0040;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h1234_5678;
    expect_grant(0, 0, 32'h40, 32'h0);
    #3 chk_idle("t1_sample");
    tick();
    #3;
    check("t1_ren",   bus.ramREN,   1'b1);
    check("t1_addr",  bus.ramaddr,  32'h40);
    check("t1_iwait", bus.iwait,    2'b10);
    check("t1_dwait", bus.dwait,    2'b11);
    check("t1_iload", bus.iload[0], 32'h1234_5678);
    tick();
    bus.iREN = '0;
    #3 chk_idle("t1_after");

    // Kind priority within one core
    tick();
    bus.dWEN[0]   = 1'b1;
    bus.dREN[0]   = 1'b1;
    bus.iREN[0]   = 1'b1;
    bus.daddr[0]  = 32'h100;
    bus.dstore[0] = 32'hDEAD_BEEF;
    bus.iaddr[0]  = 32'h200;
    bus.ramload   = 32'hA5A5_0001;
    expect_grant(0, 2, 32'h100, 32'hDEAD_BEEF);
    expect_grant(0, 1, 32'h100, 32'h0);
    expect_grant(0, 0, 32'h200, 32'h0);
    tick();
    #3;
    check("t2_w_wen",   bus.ramWEN,   1'b1);
    check("t2_w_ren",   bus.ramREN,   1'b0);
    check("t2_w_store", bus.ramstore, 32'hDEAD_BEEF);
    check("t2_w_dwait", bus.dwait,    2'b10);
    tick();
    bus.dWEN[0] = 1'b0;
    #3 chk_idle("t2_gap1");
    tick();
    #3;
    check("t2_r_ren",   bus.ramREN,   1'b1);
    check("t2_r_addr",  bus.ramaddr,  32'h100);
    check("t2_r_store", bus.ramstore, 32'h0);
    tick();
    bus.dREN[0] = 1'b0;
    #3 chk_idle("t2_gap2");
    tick();
    #3;
    check("t2_i_addr",  bus.ramaddr, 32'h200);
    check("t2_i_iwait", bus.iwait,   2'b10);
    tick();
    bus.iREN = '0;
    #3 chk_idle("t2_after");

    tick();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    #3 chk_idle("rst2");

    // Two cores holding data reads; grants land at N+1, N+3, N+5
    tick();
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h300;
    bus.daddr[1] = 32'h400;
    bus.ramstate = ACCESS;
    bus.ramload  = 32'h0BAD_F00D;
    for (int g = 0; g < 3; g++) begin
      core = RR ? (g % 2) : 0;
      expect_grant(core, 1, (core == 1) ? 32'h400 : 32'h300, 32'h0);
    end
    for (int g = 0; g < 3; g++) begin
      core = RR ? (g % 2) : 0;
      tick();
      #3;
      check("t3_dwait", bus.dwait,   (core == 1) ? 2'b01 : 2'b10);
      check("t3_addr",  bus.ramaddr, (core == 1) ? 32'h400 : 32'h300);
      tick();
      if (g == 2) bus.dREN = '0;
      #3 chk_idle("t3_gap");
    end

    // Slow RAM: three BUSY cycles then ACCESS
    tick();
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h500;
    bus.ramstate = BUSY;
    bus.ramload  = 32'hCAFE_0004;
    expect_grant(1, 1, 32'h500, 32'h0);
    for (int b = 0; b < 3; b++) begin
      tick();
      #3;
      check("t4_busy_dwait", bus.dwait,   2'b11);
      check("t4_busy_addr",  bus.ramaddr, 32'h500);
      check("t4_busy_ren",   bus.ramREN,  1'b1);
    end
    tick();
    bus.ramstate = ACCESS;
    #3;
    check("t4_acc_dwait", bus.dwait,   2'b01);
    check("t4_acc_addr",  bus.ramaddr, 32'h500);
    tick();
    bus.dREN = '0;
    #3 chk_idle("t4_after");

    // Abort of core 1 in its second GRANT cycle
    tick();
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h600;
    bus.ramstate = BUSY;
    tick();
    #3;
    check("t5_g1_dwait", bus.dwait,  2'b11);
    check("t5_g1_ren",   bus.ramREN, 1'b1);
    tick();
    bus.dREN[1]  = 1'b0;
    bus.ramstate = ACCESS;
    #3 check("t5_g2_dwait", bus.dwait, 2'b11);
    tick();
    bus.ramstate = ERROR;
    #3 chk_idle("t5_abort");

    // Abort of core 0 under ERROR; pointer must not advance past core 0
    tick();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h680;
    tick();
    #3;
    check("t5b_dwait", bus.dwait,   2'b11);
    check("t5b_addr",  bus.ramaddr, 32'h680);
    tick();
    bus.dREN[0] = 1'b0;
    #3 check("t5b_drop_dwait", bus.dwait, 2'b11);
    tick();
    #3 chk_idle("t5b_abort");
    tick();
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h700;
    bus.daddr[1] = 32'h780;
    bus.ramstate = ACCESS;
    expect_grant(0, 1, 32'h700, 32'h0);
    tick();
    #3 check("t5c_dwait", bus.dwait, 2'b10);
    tick();
    bus.dREN = '0;
    #3 chk_idle("t5c_after");

    // Reset while granted
    tick();
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h800;
    bus.dstore[0] = 32'h55;
    bus.ramstate  = BUSY;
    tick();
    #3;
    check("t6_wen",   bus.ramWEN,   1'b1);
    check("t6_store", bus.ramstore, 32'h55);
    tick();
    nRST = 1'b0;
    #3 check("t6_pre_dwait", bus.dwait, 2'b11);
    tick();
    #3 chk_idle("t6_reset");
    tick();
    bus.dWEN = '0;
    nRST     = 1'b1;
    #3 chk_idle("t6_release");

    tick();
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
